// File: rtl/mem_access_unit.sv
// Load/store unit between a single-request port and a word-wide data memory.
// Sub-word stores do read-modify-write; loads extract and extend the addressed lane.
module mem_access_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_we,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the response is a single resp_valid cycle
  // that the requester must take (no backpressure).
  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-3:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic              accept;
  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_err = (req_size == 2'd3)
                || ((req_size == 2'd1) && req_addr[0])
                || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                             state_d = S_RESP;
          else if (req_we && (req_size == 2'd2))   state_d = S_WR;
          else                                     state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    mem_we      = (state_q == S_WR);
    mem_address = (state_q == S_IDLE) ? req_addr[ADDR_W-1:2] : idx_q;
    merged      = word_q;
    case (size_q)
      2'd0:    merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
    mem_write_data = merged;
  end

  always_comb begin
    lane_b = mem_read_data[{off_q, 3'b000} +: 8];
    lane_h = mem_read_data[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_read_data;
    endcase
  end

  // Response registers change only on the edge entering RESP, so they hold between pulses.
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          idx_d   = req_addr[ADDR_W-1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            rdata_d = 32'd0;
            rerr_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        word_d = mem_read_data;
        if (!we_q) begin
          rdata_d = load_ext;
          rerr_d  = 1'b0;
        end
      end
      S_WR: begin
        rdata_d = 32'd0;
        rerr_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule
